// File: rtl/aes_pkg.sv
// AES-128 shared types, constants and GF(2^8) helpers.
// Byte 0 of a block sits in bits [127:120].
package aes_pkg;

  localparam int NR = 10;

  typedef logic [7:0]   byte_t;
  typedef logic [31:0]  word_t;
  typedef logic [127:0] block_t;

  typedef enum logic {
    IDLE,
    BUSY
  } fsm_t;

  // Indexed by round number; entry 0 and 11..15 are unused.
  localparam byte_t RCON [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04,
    8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h00
  };

  function automatic byte_t xtime(byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic word_t mix_column(word_t w);
    byte_t a0, a1, a2, a3;
    byte_t b0, b1, b2, b3;
    a0 = w[31:24];
    a1 = w[23:16];
    a2 = w[15:8];
    a3 = w[7:0];
    b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {b0, b1, b2, b3};
  endfunction

  // Row r rotates left by r columns.
  function automatic block_t shift_rows(block_t b);
    block_t o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] =
          b[127-8*(r+4*((c+r)%4)) -: 8];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_if.sv
// AES core request/response bundle.
// Master drives the block request, slave returns ciphertext.
interface aes_if;
  import aes_pkg::*;

  logic   en;
  block_t data_in;
  block_t key_in;
  block_t data_out;
  logic   data_out_valid;

  modport master (
    output en,
    output data_in,
    output key_in,
    input  data_out,
    input  data_out_valid
  );

  modport slave (
    input  en,
    input  data_in,
    input  key_in,
    output data_out,
    output data_out_valid
  );

endinterface

// File: rtl/aes_sbox.sv
// AES forward S-box, combinational 256-entry lookup.
module aes_sbox
  import aes_pkg::*;
(
  input  byte_t x,
  output byte_t y
);

  localparam logic [2047:0] TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y = TBL[(255 - int'(x)) * 8 +: 8];

endmodule

// File: rtl/aes_top.sv
// Iterative AES-128 encryptor, one round per clock.
// Round keys are expanded alongside the state.
module aes_top
  import aes_pkg::*;
(
  input  logic   AES_clk,
  input  logic   AES_rst_n,
  input  logic   AES_en,
  input  block_t AES_data_in,
  input  block_t AES_key_in,
  output block_t AES_data_out,
  output logic   AES_data_out_valid
);

  fsm_t       fsm_q;
  fsm_t       fsm_d;
  block_t     st_q;
  block_t     rk_q;
  logic [3:0] rnd_q;
  logic       load;
  logic       step;
  logic       last;

  block_t sb;
  block_t sr;
  block_t mc;
  block_t nxt;

  word_t w0, w1, w2, w3;
  word_t rot;
  word_t sw;
  word_t t;
  word_t n0, n1, n2, n3;
  block_t rk_n;

  always_ff @(posedge AES_clk) begin
    if (!AES_rst_n) fsm_q <= IDLE;
    else            fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    load  = 1'b0;
    step  = 1'b0;
    last  = 1'b0;
    unique case (fsm_q)
      IDLE: begin
        if (AES_en) begin
          load  = 1'b1;
          fsm_d = BUSY;
        end
      end
      BUSY: begin
        step = 1'b1;
        if (rnd_q == 4'(NR)) begin
          last  = 1'b1;
          fsm_d = IDLE;
        end
      end
    endcase
  end

  for (genvar i = 0; i < 16; i++) begin : g_sb
    aes_sbox u_sb (
      .x (st_q[8*i +: 8]),
      .y (sb[8*i +: 8])
    );
  end

  assign sr = shift_rows(sb);

  always_comb begin
    mc = '0;
    for (int c = 0; c < 4; c++) begin
      mc[32*c +: 32] = mix_column(sr[32*c +: 32]);
    end
  end

  assign w0  = rk_q[127:96];
  assign w1  = rk_q[95:64];
  assign w2  = rk_q[63:32];
  assign w3  = rk_q[31:0];
  assign rot = {w3[23:0], w3[31:24]};

  for (genvar k = 0; k < 4; k++) begin : g_ks
    aes_sbox u_ks (
      .x (rot[8*k +: 8]),
      .y (sw[8*k +: 8])
    );
  end

  assign t    = sw ^ {RCON[rnd_q], 24'h0};
  assign n0   = w0 ^ t;
  assign n1   = w1 ^ n0;
  assign n2   = w2 ^ n1;
  assign n3   = w3 ^ n2;
  assign rk_n = {n0, n1, n2, n3};

  // Final round skips MixColumns.
  assign nxt = last ? (sr ^ rk_n) : (mc ^ rk_n);

  always_ff @(posedge AES_clk) begin
    if (!AES_rst_n) begin
      st_q               <= '0;
      rk_q               <= '0;
      rnd_q              <= '0;
      AES_data_out       <= '0;
      AES_data_out_valid <= 1'b0;
    end else begin
      AES_data_out_valid <= last;
      if (load) begin
        st_q  <= AES_data_in ^ AES_key_in;
        rk_q  <= AES_key_in;
        rnd_q <= 4'd1;
      end else if (step) begin
        st_q  <= nxt;
        rk_q  <= rk_n;
        rnd_q <= rnd_q + 4'd1;
      end
      if (last) AES_data_out <= nxt;
    end
  end

endmodule

// File: tb/tb_aes_top.sv
// Directed FIPS-197 vector bench for aes_top.
// Expected ciphertexts are the published values.
module tb_aes_top;
  import aes_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  aes_if bus ();

  aes_top dut (
    .AES_clk            (clk),
    .AES_rst_n          (rst_n),
    .AES_en             (bus.en),
    .AES_data_in        (bus.data_in),
    .AES_key_in         (bus.key_in),
    .AES_data_out       (bus.data_out),
    .AES_data_out_valid (bus.data_out_valid)
  );

  localparam block_t KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam block_t DB = 128'h3243f6a8885a308d313198a2e0370734;
  localparam block_t CB = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam block_t KC = 128'h000102030405060708090a0b0c0d0e0f;
  localparam block_t DC = 128'h00112233445566778899aabbccddeeff;
  localparam block_t CC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam block_t CZ = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_block(string tag, block_t k, block_t d, block_t exp);
    int n;
    bus.key_in  = k;
    bus.data_in = d;
    bus.en      = 1'b1;
    tick();
    bus.en      = 1'b0;
    bus.data_in = ~d;
    bus.key_in  = ~k;
    n = 0;
    while (!bus.data_out_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, 128'(n), 128'd10);
    chk({tag, "_ct"}, bus.data_out, exp);
    tick();
    chk({tag, "_vld_drop"}, 128'(bus.data_out_valid), 128'd0);
  endtask

  initial begin
    int     pulses;
    int     last_i;
    int     gap_bad;
    int     ct_bad;
    block_t held;

    total       = 0;
    bad         = 0;
    rst_n       = 1'b0;
    bus.en      = 1'b0;
    bus.data_in = '0;
    bus.key_in  = '0;
    tick();
    tick();
    chk("rst_out", bus.data_out, '0);
    chk("rst_vld", 128'(bus.data_out_valid), 128'd0);
    rst_n = 1'b1;
    tick();

    run_block("appb", KB, DB, CB);
    run_block("appc", KC, DC, CC);
    run_block("zero", '0, '0, CZ);

    // Output holds with en low; idle input churn is ignored.
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      bus.data_in = {4{$urandom()}};
      bus.key_in  = {4{$urandom()}};
      tick();
      if (bus.data_out_valid) pulses++;
    end
    chk("idle_pulses", 128'(pulses), 128'd0);
    chk("idle_hold", bus.data_out, CZ);

    // en held high: back-to-back blocks every 11 cycles.
    bus.key_in  = KB;
    bus.data_in = DB;
    bus.en      = 1'b1;
    pulses  = 0;
    last_i  = 1;
    gap_bad = 0;
    ct_bad  = 0;
    for (int i = 1; i <= 50; i++) begin
      tick();
      if (i == 3) bus.data_in = 128'hdeadbeef_00000000_cafef00d_12345678;
      if (i == 8) bus.data_in = DB;
      if (bus.data_out_valid) begin
        pulses++;
        if (i - last_i != ((pulses == 1) ? 10 : 11)) gap_bad++;
        if (bus.data_out !== CB) ct_bad++;
        last_i = i;
      end
    end
    bus.en = 1'b0;
    chk("b2b_pulses", 128'(pulses), 128'd4);
    chk("b2b_gaps", 128'(gap_bad), 128'd0);
    chk("b2b_ct", 128'(ct_bad), 128'd0);
    for (int i = 0; i < 12; i++) tick();
    chk("b2b_tail_ct", bus.data_out, CB);

    // Abort with reset in round 5.
    bus.key_in  = KC;
    bus.data_in = DC;
    bus.en      = 1'b1;
    tick();
    bus.en = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst_n = 1'b0;
    tick();
    chk("abort_out", bus.data_out, '0);
    chk("abort_vld", 128'(bus.data_out_valid), 128'd0);
    rst_n  = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.data_out_valid) pulses++;
    end
    chk("abort_pulses", 128'(pulses), 128'd0);
    chk("abort_hold", bus.data_out, '0);

    run_block("post_rst", KB, DB, CB);
    held = bus.data_out;
    for (int i = 0; i < 3; i++) tick();
    chk("final_hold", held, CB);
    chk("final_out", bus.data_out, CB);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_top.md
Name: aes_top

Overview:
- Iterative AES-128 encryption core (FIPS-197, encrypt only) for the AES datapath top level.
- Accepts a 128-bit plaintext and a 128-bit key when enabled.
- Runs one round per clock and expands the round keys on the fly.
- Presents the ciphertext with a one-cycle valid pulse.

Parameters:
- None. Key size is fixed at 128 bits and Nr is fixed at 10.

Ports:
- AES_clk  input  1  system clock; all state updates on the rising edge.
- AES_rst_n  input  1  reset, synchronous, active-low.
- AES_en  input  1  start request; level-sensitive, sampled only while idle.
- AES_data_in  input  128  plaintext; bits [127:120] are state byte 0 (FIPS byte order, column-major).
- AES_key_in  input  128  cipher key; same byte order as AES_data_in.
- AES_data_out  output  128  ciphertext; same byte order.
- AES_data_out_valid  output  1  one-cycle pulse marking a new AES_data_out.

Behaviour:
- Reset (AES_rst_n=0 at a clock edge) clears all of the following to 0: state, round key, round counter, busy, AES_data_out, AES_data_out_valid.
- Reset has priority over everything. Reset mid-encryption aborts it and produces no valid pulse.
- Two states: IDLE and BUSY.
- IDLE with AES_en=1 at edge E0:
  - state <= AES_data_in ^ AES_key_in (initial AddRoundKey).
  - roundkey <= AES_key_in.
  - round <= 1; go to BUSY.
- IDLE with AES_en=0: hold.
- BUSY at edges E1..E10, for round r:
  - Compute rk_r from rk_{r-1}: RotWord, SubWord, Rcon[r] = 01,02,04,08,10,20,40,80,1b,36 in the MSB of word 0, then the xor chain w1..w3.
  - Rounds 1-9: state <= MixColumns(ShiftRows(SubBytes(state))) ^ rk_r.
  - Round 10: state <= ShiftRows(SubBytes(state)) ^ rk_10, with no MixColumns.
- At E10:
  - AES_data_out <= round-10 result.
  - AES_data_out_valid <= 1 for exactly one cycle.
  - Return to IDLE.
- Latency: ciphertext and valid are visible in the cycle after E10, i.e. 10 cycles after the capture edge.
- While BUSY, AES_en, AES_data_in and AES_key_in are ignored. Inputs may change freely after E0.
- AES_en held high: a new block is captured at E11, the first IDLE edge, giving back-to-back operation with one block per 11 cycles.
- AES_data_out holds its last ciphertext until the next completion or reset. It never shows intermediate state.
- AES_data_out_valid is 0 at all other times.
- Arithmetic: all operations are byte-wise in GF(2^8) with polynomial 0x11b.
  - xtime(b) = (b<<1) ^ (b[7] ? 0x1b : 0).
  - MixColumns matrix rows: [02 03 01 01] rotated per row.
- S-box: combinational 256-entry FIPS table. 16 instances serve the state, 4 serve the key schedule.

Decomposition:
- Shared package aes_pkg holds:
  - Nr=10 and the Rcon constant array.
  - State/word typedefs (byte, 32-bit word, 128-bit block).
  - Functions xtime, mix_column and shift_rows.
- One natural sub-module: aes_sbox (8-bit in, 8-bit out, combinational lookup), instantiated 20 times.
- Round logic and key expansion stay inline in aes_top.

Test Plan:
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, data 3243f6a8885a308d313198a2e0370734, AES_en pulse 1 cycle -> valid pulse 10 cycles later, AES_data_out = 3925841d02dc09fbdc118597196a0b32.
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, data 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a.
- All-zero key and data -> 66e94bd4ef8a2c3b884cfa59ca342b2e. Output then holds after valid drops and en is low.
- AES_en held high for 50 cycles with constant inputs -> valid pulses exactly every 11 cycles, same ciphertext each time. Changing AES_data_in mid-block does not alter that block's result.
- Reset asserted at round 5 -> no valid pulse; outputs read 0 on the next cycle. A fresh start after reset yields the correct App. B result.
- Inputs toggled while AES_en=0 and idle -> no valid pulse and AES_data_out unchanged.
